rom_stream_reader: RTL and testbench

Address sequencer and output buffer placed directly upstream of a synchronous ROM. It accepts a burst command (base address, word count), drives the ROM address port with consecutive addresses, and re-times the one-cycle-latency ROM read data into a valid/ready stream. Full throughput is one word per cycle, and backpressure is handled without losing words. It is the standard front end for streaming constant tables out of ROM primitives.

---
 rtl/rom_stream_pkg.sv | 22 ++
 rtl/rom_stream_fifo.sv | 55 +++++
 rtl/rom_stream_reader.sv | 141 ++++++++++++++
 tb/tb_rom_stream_reader.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg
// Shared types and constants for the ROM stream reader.
//   state_t      : sequencer states
//   FIFO_DEPTH   : output buffer depth
//   ROM_LAT      : ROM read latency in cycles (address to data)
//   CREDIT_LIMIT : max words buffered plus in flight before issue stalls
//   CNT_W        : width of the FIFO occupancy count
package rom_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH   = 4;
    localparam int ROM_LAT      = 1;
    localparam int CREDIT_LIMIT = FIFO_DEPTH;
    localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/rom_stream_fifo.sv
// rom_stream_fifo
// Small synchronous FIFO holding {last, data} words for the output stream.
// Push and pop may happen in the same cycle. dout shows the head entry.
// Ports:
//   clock, reset : clock and async active-high reset
//   push, pop    : write / read strobes (ignored when full / empty)
//   din, dout    : entry in / head entry out
//   count, empty : occupancy and empty flag (registered)
module rom_stream_fifo
    import rom_stream_pkg::*;
#(
    parameter int W = 33
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// rom_stream_reader
// Streams a burst of consecutive ROM words out as a valid/ready stream.
// Ports:
//   clock, reset              : clock and async active-high reset
//   start_valid/ready/base/len: burst command (accepted only in IDLE)
//   rom_addr, rom_data        : registered ROM address, ROM data (1-cycle latency)
//   out_valid/ready/data/last : output stream
//   busy, done                : burst in progress, one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for a command; start_ready high
// RUN   | issuing addresses as credit allows
// DRAIN | all addresses issued; waiting for the last word to be taken
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ADDR_W-1:0] start_base,
    input  logic [LEN_W-1:0]  start_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t             state;
    logic [ADDR_W-1:0]  next_addr;
    logic [LEN_W-1:0]   remaining;
    // Bit i set: a word issued i+1 edges ago has not reached the FIFO yet.
    logic [ROM_LAT:0]   iss_pipe;
    logic [ROM_LAT:0]   last_pipe;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic [DATA_W:0]    fifo_dout;
    logic [CNT_W:0]     credit_used;
    logic               accept;
    logic               pop;
    logic               credit_ok;
    logic               issue;
    logic               issue_last;

    assign start_ready = (state == IDLE);
    assign accept      = start_valid && start_ready;
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign out_last    = fifo_dout[DATA_W];
    assign out_data    = fifo_dout[DATA_W-1:0];

    // Occupancy at the start of the cycle; a same-cycle pop earns no credit.
    assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'($countones(iss_pipe));
    assign credit_ok   = credit_used < (CNT_W+1)'(CREDIT_LIMIT);

    // The first address goes out on the accept edge so rom_addr=base the next cycle.
    always_comb begin
        issue      = 1'b0;
        issue_last = 1'b0;
        if (state == IDLE) begin
            issue      = accept && (start_len != '0);
            issue_last = accept && (start_len == LEN_W'(1));
        end else if (state == RUN) begin
            issue      = credit_ok;
            issue_last = credit_ok && (remaining == LEN_W'(1));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rom_addr  <= '0;
            next_addr <= '0;
            remaining <= '0;
            iss_pipe  <= '0;
            last_pipe <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= 1'b0;
            iss_pipe  <= {iss_pipe[ROM_LAT-1:0], issue};
            last_pipe <= {last_pipe[ROM_LAT-1:0], issue_last};
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (start_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            rom_addr  <= start_base;
                            next_addr <= start_base + ADDR_W'(1);
                            remaining <= start_len - LEN_W'(1);
                            busy      <= 1'b1;
                            state     <= (start_len == LEN_W'(1)) ? DRAIN : RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        rom_addr  <= next_addr;
                        next_addr <= next_addr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The last-tagged word is the final one, so nothing else is pending.
                    if (pop && out_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rom_stream_fifo #(
        .W(DATA_W + 1)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (iss_pipe[ROM_LAT]),
        .pop   (pop),
        .din   ({last_pipe[ROM_LAT], rom_data}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;

    logic        clock;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [4:0]  start_base;
    logic [5:0]  start_len;
    logic [4:0]  rom_addr;
    logic [31:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    rom_stream_reader dut (
        .clock       (clock),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_base  (start_base),
        .start_len   (start_len),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Registered ROM: data = A5A50000 | addr
    always @(posedge clock) rom_data <= 32'hA5A50000 | {27'd0, rom_addr};

    int checks = 0;
    int errors = 0;

    logic [31:0] obs_d[$];
    bit          obs_l[$];
    int          obs_c[$];
    logic [4:0]  addr_log[$];
    bit          busy_log[$];
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    int done_cyc, done_cnt, vseen, sr_low, unstable, drops;

    // Reference: a burst is len words from consecutive addresses modulo 32.
    task automatic model_burst(input int base, input int len);
        for (int i = 0; i < len; i++) begin
            exp_d.push_back(32'hA5A50000 | 32'((base + i) % 32));
            exp_l.push_back(i == len - 1);
        end
    endtask

    // Drives one command from cycle 0 and records what the DUT does until
    // two cycles after done (or a cycle budget runs out).
    task automatic run_burst(input int base, input int len, input int lo, input int hi, input bit rnd);
        bit pv, pr, pl;
        logic [31:0] pd;
        obs_d.delete(); obs_l.delete(); obs_c.delete(); addr_log.delete(); busy_log.delete();
        done_cyc = -1; done_cnt = 0; vseen = 0; sr_low = 0; unstable = 0; drops = 0;
        pv = 0; pr = 0; pl = 0; pd = '0;
        start_base  = 5'(base);
        start_len   = 6'(len);
        start_valid = 1'b1;
        out_ready   = (0 >= lo && 0 <= hi) ? 1'b0 : 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            addr_log.push_back(rom_addr);
            busy_log.push_back(busy);
            if (!start_ready && (c == 0 || done_cyc < 0 && busy == 1'b0)) sr_low++;
            if (out_valid) vseen++;
            if (pv && !pr) begin
                if (!out_valid) drops++;
                else if (out_data !== pd || out_last !== pl) unstable++;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            if (out_valid && out_ready) begin
                obs_d.push_back(out_data);
                obs_l.push_back(out_last);
                obs_c.push_back(c);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
            @(posedge clock);
            #1;
            start_valid = 1'b0;
            out_ready = (c + 1 >= lo && c + 1 <= hi) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({start_ready, rom_addr, out_valid, out_data, out_last, busy, done} !== {1'b1, 5'd0, 1'b0, 32'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_values: got sr=%b addr=%0d v=%b d=%h l=%b busy=%b done=%b, required sr=1 addr=0 v=0 d=0 l=0 busy=0 done=0",
                     start_ready, rom_addr, out_valid, out_data, out_last, busy, done);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        exp_d.delete(); exp_l.delete();
        model_burst(2, 4);
        run_burst(2, 4, -1, -1, 1'b0);
        checks++;
        if (obs_d.size() != exp_d.size()) begin
            errors++; $display("FAIL basic_count: got %0d words, required %0d", obs_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i] || obs_c[i] != 3 + i) begin
                errors++;
                $display("FAIL basic_word[%0d]: got %h last=%0b cyc=%0d, required %h last=%0b cyc=%0d",
                         i, obs_d[i], obs_l[i], obs_c[i], exp_d[i], exp_l[i], 3 + i);
            end
        end
        checks++;
        if (addr_log[1] !== 5'd2) begin
            errors++; $display("FAIL basic_first_addr: got %0d, required 2", addr_log[1]);
        end
        checks++;
        if (done_cyc != 7 || done_cnt != 1) begin
            errors++; $display("FAIL basic_done: got cycle %0d count %0d, required cycle 7 count 1", done_cyc, done_cnt);
        end
        begin
            int bad = 0;
            for (int c = 0; c < busy_log.size(); c++)
                if (busy_log[c] != (c >= 1 && c < done_cyc)) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL basic_busy: got %0d wrong busy cycles, required 0", bad);
            end
        end
    endtask

    task automatic test_wrap();
        exp_d.delete(); exp_l.delete();
        model_burst(30, 4);
        run_burst(30, 4, -1, -1, 1'b0);
        checks++;
        if ({addr_log[1], addr_log[2], addr_log[3], addr_log[4]} !== {5'd30, 5'd31, 5'd0, 5'd1}) begin
            errors++;
            $display("FAIL wrap_addr: got %0d,%0d,%0d,%0d, required 30,31,0,1", addr_log[1], addr_log[2], addr_log[3], addr_log[4]);
        end
        checks++;
        if (obs_d.size() != exp_d.size()) begin
            errors++; $display("FAIL wrap_count: got %0d words, required %0d", obs_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL wrap_word[%0d]: got %h/%0b, required %h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_d.delete(); exp_l.delete();
        model_burst(0, 32);
        run_burst(0, 32, 3, 12, 1'b0);
        // With no pops, at most 4 words can be buffered or in flight: addresses 0..3.
        checks++;
        if (addr_log[12] !== 5'd3 || addr_log[13] !== 5'd3) begin
            errors++;
            $display("FAIL stall_addr: got %0d,%0d in cycles 12,13, required 3,3", addr_log[12], addr_log[13]);
        end
        checks++;
        if (unstable != 0 || drops != 0) begin
            errors++; $display("FAIL stall_hold: got %0d changes and %0d drops, required 0 and 0", unstable, drops);
        end
        checks++;
        if (obs_d.size() != exp_d.size()) begin
            errors++; $display("FAIL stall_count: got %0d words, required %0d", obs_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL stall_word[%0d]: got %h/%0b, required %h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_zero_len();
        int bad = 0;
        run_burst(9, 0, -1, -1, 1'b0);
        checks++;
        if (done_cyc != 1 || done_cnt != 1) begin
            errors++; $display("FAIL zero_done: got cycle %0d count %0d, required cycle 1 count 1", done_cyc, done_cnt);
        end
        for (int c = 0; c < busy_log.size(); c++) if (busy_log[c]) bad++;
        checks++;
        if (vseen != 0 || sr_low != 0 || bad != 0) begin
            errors++;
            $display("FAIL zero_quiet: got valid=%0d ready_low=%0d busy=%0d cycles, required 0,0,0", vseen, sr_low, bad);
        end
    endtask

    task automatic test_mid_reset();
        int dbad = 0;
        start_base = 5'd5; start_len = 6'd8; start_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            start_valid = 1'b0;
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({start_ready, rom_addr, out_valid, out_data, out_last, busy, done} !== {1'b1, 5'd0, 1'b0, 32'd0, 3'b000}) begin
            errors++;
            $display("FAIL midreset_values: got sr=%b addr=%0d v=%b d=%h l=%b busy=%b done=%b, required sr=1 addr=0 v=0 d=0 l=0 busy=0 done=0",
                     start_ready, rom_addr, out_valid, out_data, out_last, busy, done);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (done || out_valid) dbad++;
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (done || out_valid) dbad++;
        end
        checks++;
        if (dbad != 0) begin
            errors++; $display("FAIL midreset_quiet: got %0d cycles with done/valid, required 0", dbad);
        end
        @(posedge clock);
        #1;
        exp_d.delete(); exp_l.delete();
        model_burst(10, 2);
        run_burst(10, 2, -1, -1, 1'b0);
        checks++;
        if (obs_d.size() != 2 || done_cyc != 5) begin
            errors++; $display("FAIL midreset_after: got %0d words done cycle %0d, required 2 words done cycle 5", obs_d.size(), done_cyc);
        end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL midreset_word[%0d]: got %h/%0b, required %h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int base = int'($urandom_range(0, 31));
            int len  = int'($urandom_range(1, 32));
            exp_d.delete(); exp_l.delete();
            model_burst(base, len);
            run_burst(base, len, -1, -1, 1'b1);
            checks++;
            if (obs_d.size() != exp_d.size() || done_cnt != 1 || unstable != 0 || drops != 0) begin
                errors++;
                $display("FAIL rand%0d_summary: got words=%0d done=%0d changes=%0d drops=%0d, required words=%0d done=1 changes=0 drops=0",
                         n, obs_d.size(), done_cnt, unstable, drops, exp_d.size());
            end
            for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
                checks++;
                if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL rand%0d_word[%0d]: got %h/%0b, required %h/%0b", n, i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int dn[$];
        bool_loop: begin end
        exp_d.delete(); exp_l.delete(); obs_d.delete(); obs_l.delete();
        model_burst(7, 3);
        model_burst(20, 5);
        start_base = 5'd7; start_len = 6'd3; start_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 100 && dn.size() < 2; c++) begin
            @(negedge clock);
            if (start_valid && start_ready) acc.push_back(c);
            if (out_valid && out_ready) begin
                obs_d.push_back(out_data);
                obs_l.push_back(out_last);
            end
            if (done) dn.push_back(c);
            @(posedge clock);
            #1;
            start_base = 5'd20; start_len = 6'd5;
            if (acc.size() >= 2) start_valid = 1'b0;
        end
        start_valid = 1'b0;
        checks++;
        if (acc.size() != 2 || acc[0] != 0 || acc[1] != 6) begin
            errors++; $display("FAIL b2b_accept: got %0d accepts (2nd at %0d), required 2 accepts at 0 and 6",
                               acc.size(), acc.size() > 1 ? acc[1] : -1);
        end
        checks++;
        if (dn.size() != 2 || dn[0] != 6 || dn[1] != 14) begin
            errors++; $display("FAIL b2b_done: got %0d dones (%0d,%0d), required 2 at 6 and 14",
                               dn.size(), dn.size() > 0 ? dn[0] : -1, dn.size() > 1 ? dn[1] : -1);
        end
        checks++;
        if (obs_d.size() != exp_d.size()) begin
            errors++; $display("FAIL b2b_count: got %0d words, required %0d", obs_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL b2b_word[%0d]: got %h/%0b, required %h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        start_valid = 1'b0;
        start_base = '0;
        start_len = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
